// File: rtl/interp_buffer_ctrl_if.sv
// Handshake and buffer-port bundle between the interpolation buffer sequencer,
// the first/second-pass filters and the 9-entry row buffer.
interface interp_buffer_ctrl_if #(
  parameter int DATA_W = 165,
  parameter int ADDR_W = 4
);
  logic              START;
  logic              ABORT;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] IN_DATA;
  logic [ADDR_W-1:0] BUF_ADDR_SEL;
  logic [DATA_W-1:0] BUF_DATA_IN;
  logic              BUF_WRITE_EN;
  logic              BUF_READ_EN;
  logic [DATA_W-1:0] BUF_DATA_OUT;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic [ADDR_W-1:0] OUT_INDEX;
  logic              OUT_LAST;
  logic              BUSY;
  logic              DONE;

  // Sequencer view.
  modport master (
    input  START, ABORT, IN_VALID, IN_DATA, BUF_DATA_OUT, OUT_READY,
    output IN_READY, BUF_ADDR_SEL, BUF_DATA_IN, BUF_WRITE_EN, BUF_READ_EN,
           OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, BUSY, DONE
  );

  // Surrounding datapath view.
  modport slave (
    output START, ABORT, IN_VALID, IN_DATA, BUF_DATA_OUT, OUT_READY,
    input  IN_READY, BUF_ADDR_SEL, BUF_DATA_IN, BUF_WRITE_EN, BUF_READ_EN,
           OUT_VALID, OUT_DATA, OUT_INDEX, OUT_LAST, BUSY, DONE
  );
endinterface

// File: rtl/interp_buffer_ctrl.sv
// Sequencer for the second-pass row buffer: fills DEPTH rows from the first pass,
// then reads them back one at a time and presents each to the second pass.
module interp_buffer_ctrl #(
  parameter int DEPTH  = 9,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 165
) (
  input logic                  CLK,
  input logic                  RST_ASYNC_N,
  interp_buffer_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, FILL, READ, PRESENT, FIN} state_e;
  typedef logic [ADDR_W-1:0] idx_t;
  typedef logic [DATA_W-1:0] row_t;

  localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

  state_e state_q, state_d;
  idx_t   wr_q, wr_d, rd_q, rd_d;
  idx_t   addr_q;
  logic   in_ready_q, read_en_q, out_valid_q, out_last_q, busy_q, done_q;
  logic   wr_fire, out_fire;

  assign wr_fire  = in_ready_q & bus.IN_VALID;
  assign out_fire = out_valid_q & bus.OUT_READY;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (bus.ABORT) begin
      state_d = IDLE;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.START) begin
            state_d = FILL;
            wr_d    = '0;
          end
        end
        FILL: begin
          if (wr_fire) begin
            if (wr_q == LAST_IDX) begin
              state_d = READ;
              rd_d    = '0;
            end else begin
              wr_d = wr_q + 1'b1;
            end
          end
        end
        READ: state_d = PRESENT;
        PRESENT: begin
          if (out_fire) begin
            if (rd_q == LAST_IDX) begin
              state_d = FIN;
            end else begin
              state_d = READ;
              rd_d    = rd_q + 1'b1;
            end
          end
        end
        FIN: begin
          state_d = IDLE;
          wr_d    = '0;
          rd_d    = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      addr_q      <= '0;
      in_ready_q  <= 1'b0;
      read_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      in_ready_q  <= (state_d == FILL);
      read_en_q   <= (state_d == READ);
      out_valid_q <= (state_d == PRESENT);
      out_last_q  <= (state_d == PRESENT) && (rd_d == LAST_IDX);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == FIN);
      unique case (state_d)
        FILL:          addr_q <= wr_d;
        READ, PRESENT: addr_q <= rd_d;
        default:       addr_q <= '0;
      endcase
    end
  end

  assign bus.IN_READY     = in_ready_q;
  assign bus.BUF_WRITE_EN = wr_fire;
  assign bus.BUF_DATA_IN  = row_t'(bus.IN_DATA);
  assign bus.BUF_ADDR_SEL = addr_q;
  assign bus.BUF_READ_EN  = read_en_q;
  // The buffer output holds between reads, so the row is passed straight through.
  assign bus.OUT_DATA     = row_t'(bus.BUF_DATA_OUT);
  assign bus.OUT_VALID    = out_valid_q;
  assign bus.OUT_INDEX    = rd_q;
  assign bus.OUT_LAST     = out_last_q;
  assign bus.BUSY         = busy_q;
  assign bus.DONE         = done_q;
endmodule
